// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx: PS/2 set-2 receiver producing the held-key scancode for the movement logic.
// Define PS2_EXTENDED_EN to track E0 prefixes and report them on is_extended.
module ps2_keyboard_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key_code,
    output logic [7:0] code_byte,
    output logic       code_valid,
    output logic       is_break,
    output logic       is_extended,
    output logic       frame_err
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] F_MAX = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYCLES - 1);
`ifdef PS2_EXTENDED_EN
    localparam logic EXT_EN = 1'b1;
`else
    localparam logic EXT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]    clk_sync, dat_sync;
    logic [FW-1:0] fcnt;
    logic          filt, filt_d, fall, dat;
    state_t        state, state_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    shift, shift_n;
    logic          par, par_n;
    logic [TW-1:0] tcnt;
    logic          accept, err;
    logic          brk_pend, ext_pend;

    // The filtered clock flips only after FILTER_LEN consecutive samples disagree with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            fcnt     <= '0;
            filt     <= 1'b1;
            filt_d   <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_data};
            filt_d   <= filt;
            if (clk_sync[1] == filt) begin
                fcnt <= '0;
            end else if (fcnt == F_MAX) begin
                fcnt <= '0;
                filt <= clk_sync[1];
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end
    end

    assign fall = filt_d & ~filt;
    assign dat  = dat_sync[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            idx   <= '0;
            shift <= '0;
            par   <= 1'b0;
            tcnt  <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            shift <= shift_n;
            par   <= par_n;
            tcnt  <= (fall || state == IDLE) ? '0 : tcnt + 1'b1;
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        shift_n = shift;
        par_n   = par;
        accept  = 1'b0;
        err     = 1'b0;
        if (fall) begin
            case (state)
                IDLE: begin
                    state_n = dat ? IDLE : DATA;
                    idx_n   = '0;
                end
                DATA: begin
                    shift_n = {dat, shift[7:1]};
                    idx_n   = idx + 1'b1;
                    state_n = (idx == 3'd7) ? PARITY : DATA;
                end
                PARITY: begin
                    par_n   = dat;
                    state_n = STOP;
                end
                default: begin
                    accept  = dat & ^{shift, par};
                    err     = ~accept;
                    state_n = IDLE;
                end
            endcase
        end else if (state != IDLE && tcnt == T_MAX) begin
            state_n = IDLE;
            err     = 1'b1;
        end
    end

    // Prefixes only arm flags; 00/FF are keyboard error codes and just clear them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_code    <= 8'h00;
            code_byte   <= 8'h00;
            code_valid  <= 1'b0;
            is_break    <= 1'b0;
            is_extended <= 1'b0;
            frame_err   <= 1'b0;
            brk_pend    <= 1'b0;
            ext_pend    <= 1'b0;
        end else begin
            code_valid <= 1'b0;
            frame_err  <= err;
            if (accept) begin
                if (shift == 8'hF0) begin
                    brk_pend <= 1'b1;
                end else if (shift == 8'hE0) begin
                    ext_pend <= ext_pend | EXT_EN;
                end else begin
                    brk_pend <= 1'b0;
                    ext_pend <= 1'b0;
                    if (shift != 8'h00 && shift != 8'hFF) begin
                        code_valid  <= 1'b1;
                        code_byte   <= shift;
                        is_break    <= brk_pend;
                        is_extended <= ext_pend;
                        if (!brk_pend)
                            key_code <= shift;
                        else if (key_code == shift)
                            key_code <= 8'h00;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// tb_ps2_keyboard_rx: random and directed PS/2 frames checked against a byte-level decoder model.
module tb_ps2_keyboard_rx;
    localparam int TMO = 600;
    localparam int H   = 30;
`ifdef PS2_EXTENDED_EN
    localparam bit EXT = 1'b1;
`else
    localparam bit EXT = 1'b0;
`endif

    logic       clk = 1'b0, rst = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1;
    logic [7:0] key_code, code_byte;
    logic       code_valid, is_break, is_extended, frame_err;

    ps2_keyboard_rx #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .key_code(key_code), .code_byte(code_byte), .code_valid(code_valid),
        .is_break(is_break), .is_extended(is_extended), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         err;
        logic [7:0] key;
        logic [7:0] code;
        bit         brk;
        bit         ext;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       ce;
    int         checks = 0, failures = 0, err_seen = 0, valid_seen = 0;
    logic [7:0] exp_key = 8'h00, exp_code = 8'h00;
    bit         exp_brk = 1'b0, exp_ext = 1'b0;
    logic [7:0] m_key = 8'h00;
    bit         m_brk = 1'b0, m_ext = 1'b0;
    logic [7:0] mv [4] = '{8'h6B, 8'h74, 8'h75, 8'h72};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Byte-level decoder rules: what each received byte must produce at the outputs.
    task automatic model_byte(input logic [7:0] b, input bit good);
        exp_t e;
        e = '{err: 1'b0, key: m_key, code: b, brk: m_brk, ext: m_ext};
        if (!good) begin
            e.err = 1'b1;
            exp_q.push_back(e);
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (b == 8'hE0) begin
            m_ext = m_ext | EXT;
        end else begin
            if (b != 8'h00 && b != 8'hFF) begin
                if (!m_brk) m_key = b;
                else if (m_key == b) m_key = 8'h00;
                e.key = m_key;
                exp_q.push_back(e);
            end
            m_brk = 1'b0;
            m_ext = 1'b0;
        end
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n, input bit glitch);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            repeat (H/2) @(negedge clk);
            if (glitch) begin
                ps2_clk = 1'b0;
                repeat (5) @(negedge clk);
                ps2_clk = 1'b1;
            end
            repeat (H/2) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (H) @(negedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic drain();
        repeat (40) @(negedge clk);
        check("missing_event", exp_q.size(), 0);
        exp_q.delete();
        check("idle_key_code", key_code, exp_key);
        check("idle_code_byte", code_byte, exp_code);
        check("idle_is_break", is_break, exp_brk);
        check("idle_is_extended", is_extended, exp_ext);
    endtask

    task automatic frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input bit glitch);
        logic p;
        p = ~(^b) ^ bad_par;
        model_byte(b, !(bad_par || bad_stop));
        send_bits({~bad_stop, p, b, 1'b0}, 11, glitch);
        drain();
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            exp_key  = 8'h00;
            exp_code = 8'h00;
            exp_brk  = 1'b0;
            exp_ext  = 1'b0;
        end else if (code_valid || frame_err) begin
            check("valid_err_exclusive", code_valid & frame_err, 0);
            if (frame_err) err_seen++;
            else valid_seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_event", {code_valid, frame_err}, 0);
            end else begin
                ce = exp_q.pop_front();
                check("event_kind", frame_err, ce.err);
                if (!ce.err) begin
                    exp_key  = ce.key;
                    exp_code = ce.code;
                    exp_brk  = ce.brk;
                    exp_ext  = ce.ext;
                end
                check("key_code", key_code, exp_key);
                check("code_byte", code_byte, exp_code);
                check("is_break", is_break, exp_brk);
                check("is_extended", is_extended, exp_ext);
            end
        end
    end

    initial begin
        int e0, v0;
        repeat (3) @(negedge clk);
        check("rst_key_code", key_code, 8'h00);
        check("rst_code_byte", code_byte, 8'h00);
        check("rst_code_valid", code_valid, 0);
        check("rst_is_break", is_break, 0);
        check("rst_is_extended", is_extended, 0);
        check("rst_frame_err", frame_err, 0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        v0 = valid_seen;
        frame(8'h6B, 0, 0, 0);
        check("pin_6b_pulses", valid_seen - v0, 1);
        check("pin_6b_key", key_code, 8'h6B);
        check("pin_6b_code", code_byte, 8'h6B);
        check("pin_6b_brk", is_break, 0);

        frame(8'h75, 0, 0, 0);
        check("pin_75_key", key_code, 8'h75);
        v0 = valid_seen;
        frame(8'hF0, 0, 0, 0);
        check("pin_f0_no_pulse", valid_seen - v0, 0);
        frame(8'h75, 0, 0, 0);
        check("pin_75_rel_key", key_code, 8'h00);
        check("pin_75_rel_brk", is_break, 1);

        frame(8'h74, 0, 0, 0);
        frame(8'hF0, 0, 0, 0);
        frame(8'h6B, 0, 0, 0);
        check("pin_other_rel_key", key_code, 8'h74);
        check("pin_other_rel_code", code_byte, 8'h6B);
        check("pin_other_rel_brk", is_break, 1);

        e0 = err_seen;
        v0 = valid_seen;
        frame(8'h72, 1, 0, 0);
        frame(8'h72, 0, 1, 0);
        check("pin_bad_frames_err", err_seen - e0, 2);
        check("pin_bad_frames_valid", valid_seen - v0, 0);
        check("pin_bad_frames_key", key_code, 8'h74);

        e0 = err_seen;
        model_byte(8'h6B, 0);
        send_bits({2'b10, 8'h6B, 1'b0}, 4, 0);
        repeat (TMO + 100) @(negedge clk);
        check("pin_timeout_err", err_seen - e0, 1);
        drain();
        frame(8'h6B, 0, 0, 0);
        check("pin_after_timeout_key", key_code, 8'h6B);

        frame(8'h74, 0, 0, 1);
        check("pin_glitch_key", key_code, 8'h74);

        ps2_clk = 1'b0;
        repeat (H) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (H) @(negedge clk);
        frame(8'h72, 0, 0, 0);
        check("pin_idle_pulse_key", key_code, 8'h72);

        frame(8'hE0, 0, 0, 0);
        frame(8'h6B, 0, 0, 0);
        check("pin_ext_flag", is_extended, EXT);
        check("pin_ext_key", key_code, 8'h6B);

        send_bits({2'b10, 8'h75, 1'b0}, 5, 0);
        rst = 1'b0;
        m_key = 8'h00;
        m_brk = 1'b0;
        m_ext = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge clk);
        check("pin_midreset_key", key_code, 8'h00);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        frame(8'h75, 0, 0, 0);
        check("pin_after_reset_key", key_code, 8'h75);

        for (int i = 0; i < 60; i++) begin
            logic [7:0] b;
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 2) b = 8'hF0;
            else if (r == 2) b = 8'hE0;
            else if (r == 3) b = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
            else if (r < 8) b = mv[$urandom_range(0, 3)];
            else b = 8'($urandom);
            frame(b, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ps2_keyboard_rx.md
# ps2_keyboard_rx

Receives PS/2 set-2 frames from the keyboard and turns them into the held-key scancode byte that `vga_controller` consumes on its `led` input (0x6B/0x74/0x75/0x72 select movement). It owns the keyboard-to-FPGA direction of the link:

- pin synchronisation and clock filtering;
- 11-bit frame deserialisation with parity and stop checks;
- make/break tracking, so the movement logic sees a level that is held while a key is down and 0x00 after release.

## Interface
Parameters:
- FILTER_LEN, 8: consecutive identical `clk` samples required before the filtered PS/2 clock changes level.
- TIMEOUT_CYCLES, 200000: idle `clk` cycles mid-frame before the frame is aborted (2 ms at 100 MHz).

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous, active-low reset.
- ps2_clk  in  1  raw PS/2 clock pin; asynchronous.
- ps2_data  in  1  raw PS/2 data pin; asynchronous.
- key_code  out  8  currently held make code; 0x00 when no key is held. Drives `led`.
- code_byte  out  8  last decoded make/break code.
- code_valid  out  1  one-cycle pulse when `code_byte` updates.
- is_break  out  1  qualifies `code_byte`; 1 = release.
- is_extended  out  1  qualifies `code_byte`; 1 = E0-prefixed.
- frame_err  out  1  one-cycle pulse on a parity, stop or timeout failure.

## Operation
- **Input conditioning:** `ps2_clk` and `ps2_data` each pass through 2-FF synchronisers. The filtered clock level changes only after FILTER_LEN equal synchronised samples. A 1→0 transition of the filtered clock is the sample strobe `fall`.
- **Frame FSM:**
  - IDLE: on `fall` with data=0 (start bit), clear the bit index and go to DATA. On `fall` with data=1, stay in IDLE with no error.
  - DATA: on each `fall`, shift data in LSB-first; after the 8th bit, go to PARITY.
  - PARITY: on `fall`, capture the parity bit and go to STOP.
  - STOP: on `fall`, the byte is accepted if stop=1 and the 9 data+parity bits contain an odd number of ones. Otherwise pulse `frame_err`. Either way, return to IDLE.
- **Timeout:** the counter clears on every `fall` and counts while the FSM is not in IDLE. When it reaches TIMEOUT_CYCLES-1, the FSM returns to IDLE, pulses `frame_err` and discards the partial byte.
- **Decoder**, acting on each accepted byte B:
  - B=0xF0: set `brk_pend`.
  - B=0xE0: set `ext_pend` (see Configuration).
  - B=0x00 or 0xFF (keyboard error/overrun): clear both pending flags; no `code_valid`.
  - Any other B with `brk_pend`=1 (release):
    - `code_byte`=B, `is_break`=1, `is_extended`=`ext_pend`, pulse `code_valid`;
    - `key_code` goes to 0x00 only if it equals B; otherwise it is unchanged;
    - clear both flags.
  - Any other B with `brk_pend`=0 (make):
    - `key_code`=B, `code_byte`=B, `is_break`=0, `is_extended`=`ext_pend`, pulse `code_valid`;
    - clear both flags.
- **Typematic repeat:** a repeated make of the same code re-pulses `code_valid`; `key_code` keeps the same value.
- **Reset** (asserted at any time, including mid-frame): FSM to IDLE, synchronisers and filter to 1, pending flags to 0, the partial byte is discarded.

## Timing
- Reset values:
  - `key_code`=0x00, `code_byte`=0x00;
  - `code_valid`=0, `is_break`=0, `is_extended`=0, `frame_err`=0;
  - filtered clock=1.
- Latency from the physical ps2_clk falling edge to `fall`: 2 synchroniser cycles + FILTER_LEN cycles.
- `code_valid`, `key_code`, `code_byte`, `is_break` and `is_extended` all update in the cycle after the STOP-state `fall`. `frame_err` follows the same one-cycle rule.
- `code_valid` and `frame_err` are never asserted in the same cycle.
- Prefix bytes (F0/E0) produce no output activity.
- Glitches on `ps2_clk` shorter than FILTER_LEN cycles produce no `fall`.
- `ps2_data` is sampled from the synchronised value in the cycle `fall` is detected.

## Configuration
- **PS2_EXTENDED_EN defined:** 0xE0 sets `ext_pend`, and `is_extended` reports it as described above.
- **PS2_EXTENDED_EN undefined:**
  - 0xE0 bytes are discarded with no state change;
  - `is_extended` is tied to 0;
  - E0 6B and plain 6B decode identically.

## Test plan
Bit period is 40 µs; FILTER_LEN and TIMEOUT_CYCLES are at their defaults.

- Frame 0x6B (parity 0, stop 1) → one `code_valid`, `key_code`=0x6B, `code_byte`=0x6B, `is_break`=0.
- 0x75, then F0, then 0x75 → `key_code` goes 0x75 then 0x00; second `code_valid` has `is_break`=1. No pulse for F0.
- 0x74, then F0, then 0x6B → `key_code` stays 0x74; release pulse reports `code_byte`=0x6B with `is_break`=1.
- 0x72 with a flipped parity bit → `frame_err` pulse, no `code_valid`, `key_code` unchanged. Repeat with stop=0 → same result.
- 4 bits, then silence for 2.1 ms, then a full 0x6B frame → `frame_err` at timeout, then a clean decode of 0x6B. Separately, 50 ns glitches on `ps2_clk` → no effect.
- E0, 0x6B with PS2_EXTENDED_EN defined → `is_extended`=1, `key_code`=0x6B. Without the macro → `is_extended`=0, same `key_code`. Reset asserted mid-frame, then a clean frame → only the clean frame decodes.
